// File: rtl/fetch_buffer.sv
// fetch_buffer: circular instruction queue between fetch and decode/dispatch.
// Accepts up to N fetched instructions per cycle and presents the oldest
// up-to-N entries to the decoder. Flushes wholesale on branch restore.
// Optional macro FETCH_BUFFER_BYPASS_EN: on an empty buffer the fetch slots are
// forwarded combinationally to the decoder (zero-cycle latency).
module fetch_buffer #(
   parameter int N        = 3,
   parameter int DEPTH    = 16,
   parameter int CNT_BITS = $clog2(N + 1)
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [CNT_BITS-1:0]      fetch_count,
   input  logic [N-1:0][31:0]       fetch_inst,
   input  logic [N-1:0][31:0]       fetch_PC,
   input  logic [N-1:0][31:0]       fetch_NPC,
   output logic [CNT_BITS-1:0]      fb_spots,
   output logic [N-1:0][31:0]       fb_inst,
   output logic [N-1:0][31:0]       fb_PC,
   output logic [N-1:0][31:0]       fb_NPC,
   output logic [CNT_BITS-1:0]      instructions_valid,
   input  logic [CNT_BITS-1:0]      num_dispatched,
   input  logic                     restore_valid
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0]       N_C     = CW'(N);
   localparam logic [CW-1:0]       DEPTH_C = CW'(DEPTH);
   localparam logic [CNT_BITS-1:0] N_CNT   = CNT_BITS'(N);

   logic [31:0] inst_q [DEPTH];
   logic [31:0] pc_q   [DEPTH];
   logic [31:0] npc_q  [DEPTH];

   logic [PW-1:0]       head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]       count_q, count_d;
   logic [CW-1:0]       free_w;
   logic [CNT_BITS-1:0] stored_valid, fetch_clamped;
   logic [CNT_BITS-1:0] deq, enq_all, enq, deq_st, skip;
   logic                bypass;

`ifdef FETCH_BUFFER_BYPASS_EN
   // Forward fetch slots straight to the decoder whenever nothing is stored
   always_comb bypass = (count_q == '0) && !restore_valid;
`else
   // Strict one-cycle latency: never forward fetch slots
   always_comb bypass = 1'b0;
`endif

   // Occupancy-derived counts, from registered state only
   always_comb begin
      free_w        = DEPTH_C - count_q;
      fb_spots      = (free_w < N_C) ? free_w[CNT_BITS-1:0] : N_CNT;
      stored_valid  = (count_q < N_C) ? count_q[CNT_BITS-1:0] : N_CNT;
      fetch_clamped = (fetch_count > N_CNT) ? N_CNT : fetch_count;
   end

   // Present the oldest entries (or the bypassed fetch slots); unused slots are 0
   always_comb begin
      instructions_valid = bypass ? fetch_clamped : stored_valid;
      for (int unsigned i = 0; i < N; i++) begin
         fb_inst[i] = '0;
         fb_PC[i]   = '0;
         fb_NPC[i]  = '0;
         if (i < 32'(instructions_valid)) begin
            if (bypass) begin
               fb_inst[i] = fetch_inst[i];
               fb_PC[i]   = fetch_PC[i];
               fb_NPC[i]  = fetch_NPC[i];
            end else begin
               fb_inst[i] = inst_q[head_q + PW'(i)];
               fb_PC[i]   = pc_q[head_q + PW'(i)];
               fb_NPC[i]  = npc_q[head_q + PW'(i)];
            end
         end
      end
   end

   // Clamp dequeue/enqueue and compute next pointers and count.
   // In bypass the dispatched slots come from the incoming fetch group,
   // so storage is not dequeued and only the remainder is written.
   always_comb begin
      deq     = (num_dispatched < instructions_valid) ? num_dispatched : instructions_valid;
      enq_all = (fetch_count < fb_spots) ? fetch_count : fb_spots;
      if (bypass) begin
         skip   = deq;
         enq    = enq_all - deq;
         deq_st = '0;
      end else begin
         skip   = '0;
         enq    = enq_all;
         deq_st = deq;
      end
      head_d  = head_q + PW'(deq_st);
      tail_d  = tail_q + PW'(enq);
      count_d = count_q + CW'(enq) - CW'(deq_st);
   end

   // Pointer/count register: reset beats restore, restore beats enq/deq
   always_ff @(posedge clock) begin
      if (reset || restore_valid) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Write accepted fetch slots starting at tail; contents need no reset
   always_ff @(posedge clock) begin
      if (!reset && !restore_valid) begin
         for (int unsigned s = 0; s < N; s++) begin
            if (s >= 32'(skip) && s < 32'(skip) + 32'(enq)) begin
               inst_q[tail_q + PW'(s) - PW'(skip)] <= fetch_inst[s];
               pc_q[tail_q + PW'(s) - PW'(skip)]   <= fetch_PC[s];
               npc_q[tail_q + PW'(s) - PW'(skip)]  <= fetch_NPC[s];
            end
         end
      end
   end

endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: randomized bench for fetch_buffer against a queue model.
module tb_fetch_buffer;

   localparam int N     = 3;
   localparam int DEPTH = 16;
   localparam int CB    = $clog2(N + 1);
`ifdef FETCH_BUFFER_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic                clock = 1'b0;
   logic                reset;
   logic [CB-1:0]       fetch_count;
   logic [N-1:0][31:0]  fetch_inst, fetch_PC, fetch_NPC;
   logic [CB-1:0]       fb_spots;
   logic [N-1:0][31:0]  fb_inst, fb_PC, fb_NPC;
   logic [CB-1:0]       instructions_valid;
   logic [CB-1:0]       num_dispatched;
   logic                restore_valid;

   always #5 clock = ~clock;

   fetch_buffer #(.N(N), .DEPTH(DEPTH), .CNT_BITS(CB)) dut (
      .clock              (clock),
      .reset              (reset),
      .fetch_count        (fetch_count),
      .fetch_inst         (fetch_inst),
      .fetch_PC           (fetch_PC),
      .fetch_NPC          (fetch_NPC),
      .fb_spots           (fb_spots),
      .fb_inst            (fb_inst),
      .fb_PC              (fb_PC),
      .fb_NPC             (fb_NPC),
      .instructions_valid (instructions_valid),
      .num_dispatched     (num_dispatched),
      .restore_valid      (restore_valid)
   );

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
      logic [31:0] npc;
   } ent_t;

   ent_t        q[$];
   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int min2(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   task automatic drive(input bit rst, input bit rv, input int fc, input int nd);
      reset          = rst;
      restore_valid  = rv;
      fetch_count    = CB'(fc);
      num_dispatched = CB'(nd);
      for (int i = 0; i < N; i++) begin
         fetch_inst[i] = $urandom;
         fetch_PC[i]   = $urandom & 32'hFFFF_FFFC;
         fetch_NPC[i]  = fetch_PC[i] + 32'd4;
      end
   endtask

   // Compare outputs with the model, then advance the model past the next edge
   task automatic check_and_update();
      int   sz, iv, spots, deq, enq;
      bit   byp;
      ent_t e;
      sz    = q.size();
      byp   = BYP && (sz == 0) && !restore_valid;
      iv    = byp ? min2(int'(fetch_count), N) : min2(N, sz);
      spots = min2(N, DEPTH - sz);
      check("instructions_valid", 32'(instructions_valid), 32'(iv));
      check("fb_spots", 32'(fb_spots), 32'(spots));
      for (int i = 0; i < N; i++) begin
         if (i < iv) e = byp ? '{fetch_inst[i], fetch_PC[i], fetch_NPC[i]} : q[i];
         else        e = '0;
         check($sformatf("fb_inst[%0d]", i), fb_inst[i], e.inst);
         check($sformatf("fb_PC[%0d]", i),   fb_PC[i],   e.pc);
         check($sformatf("fb_NPC[%0d]", i),  fb_NPC[i],  e.npc);
      end
      if (reset || restore_valid) begin
         q.delete();
      end else begin
         deq = min2(int'(num_dispatched), iv);
         enq = min2(int'(fetch_count), spots);
         if (byp) begin
            for (int j = deq; j < enq; j++) q.push_back('{fetch_inst[j], fetch_PC[j], fetch_NPC[j]});
         end else begin
            repeat (deq) void'(q.pop_front());
            for (int j = 0; j < enq; j++) q.push_back('{fetch_inst[j], fetch_PC[j], fetch_NPC[j]});
         end
      end
   endtask

   initial begin
      int fc, nd;
      bit rst, rv;
      drive(1'b1, 1'b0, 0, 0);
      for (int c = 0; c < 700; c++) begin
         @(posedge clock);
         #1;
         rst = 1'b0;
         rv  = 1'b0;
         if (c < 2) begin
            rst = 1'b1; fc = 0; nd = 0;
         end else if (c < 14) begin
            fc = 3; nd = 0;                          // fill to full and beyond
         end else if (c < 22) begin
            fc = 0; nd = 3;                          // drain, ending in over-requests
         end else begin
            case ((c / 40) % 3)
               0:       begin fc = $urandom_range(2, 3); nd = $urandom_range(0, 1); end
               1:       begin fc = $urandom_range(0, 1); nd = $urandom_range(2, 3); end
               default: begin fc = $urandom_range(0, 3); nd = $urandom_range(0, 3); end
            endcase
            rv  = ($urandom_range(0, 24) == 0);
            rst = ($urandom_range(0, 79) == 0);
         end
         drive(rst, rv, fc, nd);
         if (c == 2) begin
            for (int i = 0; i < N; i++) begin
               fetch_PC[i]  = 32'(4 * i);
               fetch_NPC[i] = 32'(4 * i + 4);
            end
         end
         @(negedge clock);
         check_and_update();
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
- Circular instruction queue between the fetch unit and decode/dispatch.
- Accepts up to N fetched instructions per cycle.
- Presents the oldest up-to-N entries to the decoder, with a count that drives Dispatch's instructions_valid.
- Retires entries by Dispatch's num_dispatched; flushes wholesale on branch restore.

Parameters:
- N, 3, superscalar width: max enqueue and dequeue per cycle.
- DEPTH, 16, number of entries; power of two, DEPTH >= 2*N.
- CNT_BITS, $clog2(N+1), width of per-cycle counts (matches `NUM_SCALAR_BITS).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous active-high reset
- fetch_count  in  CNT_BITS  number of valid fetch slots this cycle, packed from slot 0
- fetch_inst  in  N x 32  fetched instruction words, slot 0 oldest
- fetch_PC  in  N x 32  PC per slot
- fetch_NPC  in  N x 32  next PC per slot
- fb_spots  out  CNT_BITS  min(N, DEPTH - count); fetch may send at most this many
- fb_inst  out  N x 32  oldest entries, slot 0 = head
- fb_PC  out  N x 32  PCs of presented entries
- fb_NPC  out  N x 32  NPCs of presented entries
- instructions_valid  out  CNT_BITS  min(N, count); number of valid fb_* slots
- num_dispatched  in  CNT_BITS  entries consumed by Dispatch this cycle
- restore_valid  in  1  branch mispredict restore; flush all entries

Behaviour:
- State: storage[DEPTH] of {inst, PC, NPC}; head and tail pointers ($clog2(DEPTH) bits, wrap modulo DEPTH); count ($clog2(DEPTH+1) bits).
- Reset (synchronous, active-high):
  - head = tail = count = 0.
  - Outputs settle combinationally: instructions_valid = 0, fb_spots = N, fb_* slots = 0.
  - Storage contents are don't-care.
- Presented slots:
  - Slot i shows storage[(head+i) mod DEPTH] for i < instructions_valid.
  - Slots at or above instructions_valid are driven 0.
- fb_spots and instructions_valid depend only on registered state: no combinational path from fetch_count or num_dispatched.
- Dequeue:
  - deq = min(num_dispatched, instructions_valid); an over-request is clamped, never underflows.
  - head advances by deq, with wrap.
- Enqueue:
  - enq = min(fetch_count, fb_spots); excess slots are dropped silently.
  - Slot j (j < enq) is written to (tail+j) mod DEPTH; tail advances by enq, with wrap.
- Space freed by a dequeue becomes visible in fb_spots only the next cycle, so same-cycle enqueue and dequeue never collide.
- Update: count_next = count + enq - deq. Full (count = DEPTH) gives fb_spots = 0; empty gives instructions_valid = 0.
- Flush:
  - restore_valid = 1 takes priority over enqueue and dequeue: next head = tail = count = 0, and all enq/deq that cycle are discarded.
  - Dispatch already forces num_dispatched = 0 during restore; the buffer ignores the value regardless.
- Reset asserted mid-operation behaves identically to a flush and has priority over restore_valid.
- Latency: an entry enqueued in cycle t is first presented in cycle t+1, unless the optional feature is compiled in.
- No FSM beyond pointer/count state; all updates on posedge clock.

Optional Feature:
- Macro: FETCH_BUFFER_BYPASS_EN.
- Defined, when count = 0 and restore_valid = 0:
  - fb_* slots mirror the fetch_* inputs combinationally, and instructions_valid = min(fetch_count, N).
  - deq is applied to the incoming slots first; only slots j >= deq are written, starting at tail, and enq becomes the remainder.
  - The result is zero-cycle fetch-to-decode latency on an empty buffer.
- Not defined: strict one-cycle latency as above; no combinational path from fetch_* to fb_* or instructions_valid.

Test Plan:
- Reset, then fetch_count=3 (PCs 0x0, 0x4, 0x8) with num_dispatched=0 -> next cycle instructions_valid=3, fb_PC = {0x0, 0x4, 0x8}, count=3, fb_spots=3.
- Fill to 16 entries with no dispatch -> fb_spots=0; a fetch_count=3 offered in that cycle is dropped and count stays 16.
- Wrap-around: head=14, count=4, num_dispatched=3, fetch_count=3 -> head=1, tail=5 (was 2), count=4; fb_PC ordering stays contiguous across index 15→0.
- Over-request: count=2, num_dispatched=3 -> deq clamped to 2, count=0, instructions_valid=0 next cycle, no underflow.
- Flush: count=7, restore_valid=1 with fetch_count=3 and num_dispatched=2 -> next cycle count=0, instructions_valid=0, fb_spots=3; new fetches accepted the following cycle.
- With FETCH_BUFFER_BYPASS_EN, empty buffer, fetch_count=3, num_dispatched=2 -> same cycle instructions_valid=3 and fb_PC slot0 = fetch_PC slot0; next cycle count=1 holding the slot-2 instruction.
